// File: rtl/bitwise_logic_unit.sv
// rtl/bitwise_logic_unit.sv - registered bitwise AND/OR/XOR/NOR unit with accumulator and valid/ready handshake
// Optional macro: LOGIC_ZERO_FLAG_EN adds a registered zero flag on port zero.
module bitwise_logic_unit #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             acc_mode,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [CNT_W-1:0] txn_cnt
`ifdef LOGIC_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;

  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_valid;
  logic             w_accept;
  logic             w_deliver;
  logic [WIDTH-1:0] w_src;
  logic [WIDTH-1:0] w_result;

  // Handshake: a stalled result blocks input; a delivering result frees the slot in the same cycle
  always_comb begin
    in_ready  = !r_valid || out_ready;
    w_accept  = in_valid && in_ready;
    w_deliver = r_valid && out_ready;
  end

  // Operand select and bitwise operation; a clear arriving with an accumulate op reads as zero
  always_comb begin
    w_src = b;
    if (acc_mode) begin
      w_src = acc_clr ? '0 : r_acc;
    end
    case (op)
      OP_AND:  w_result = a & w_src;
      OP_OR:   w_result = a | w_src;
      OP_XOR:  w_result = a ^ w_src;
      default: w_result = ~(a | w_src);
    endcase
  end

  // Result register, valid flag and delivery counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out   <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_out   <= w_result;
        r_valid <= 1'b1;
      end else if (w_deliver) begin
        r_valid <= 1'b0;
      end
      if (w_deliver) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Accumulator: an accepted accumulate op takes the result, which beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
    end else if (w_accept && acc_mode) begin
      r_acc <= w_result;
    end else if (acc_clr) begin
      r_acc <= '0;
    end
  end

`ifdef LOGIC_ZERO_FLAG_EN
  logic r_zero;

  // Zero flag tracks the result register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_zero <= 1'b1;
    end else if (w_accept) begin
      r_zero <= (w_result == '0);
    end
  end

  assign zero = r_zero;
`endif

  assign out_valid = r_valid;
  assign out       = r_out;
  assign txn_cnt   = r_cnt;

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// tb/tb_bitwise_logic_unit.sv - scoreboard bench for bitwise_logic_unit (define LOGIC_ZERO_FLAG_EN to cover zero)
module tb_bitwise_logic_unit;

  localparam int WIDTH = 5;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [1:0]       op = 2'b00;
  logic             acc_mode = 1'b0;
  logic             acc_clr = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out;
  logic [CNT_W-1:0] txn_cnt;
`ifdef LOGIC_ZERO_FLAG_EN
  logic             zero;
`endif

  bitwise_logic_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .acc_mode(acc_mode), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .txn_cnt(txn_cnt)
`ifdef LOGIC_ZERO_FLAG_EN
    , .zero(zero)
`endif
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] m_acc = '0;
  int               m_cnt = 0;
  bit               exp_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_op(input logic [1:0] o, input int x, input int y);
    int r;
    int mask;
    mask = (1 << WIDTH) - 1;
    case (o)
      2'd0:    r = x & y;
      2'd1:    r = x | y;
      2'd2:    r = x ^ y;
      default: r = mask - ((x | y) & mask);
    endcase
    return WIDTH'(r & mask);
  endfunction

  // One cycle of stimulus; predicts accept from the bench's own notion of a pending result
  task automatic do_txn(input bit iv, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                        input logic [1:0] top, input bit am, input bit clr, input bit ordy);
    bit               rdy;
    bit               acc_ok;
    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] res;
    @(posedge clk);
    #1;
    in_valid = iv; a = ta; b = tb; op = top; acc_mode = am; acc_clr = clr; out_ready = ordy;
    #1;
    rdy = !exp_valid || ordy;
    chk("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
    chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    acc_ok = iv && rdy;
    if (acc_ok) begin
      src = am ? (clr ? '0 : m_acc) : tb;
      res = ref_op(top, int'(ta), int'(src));
      exp_q.push_back(res);
      if (am) m_acc = res;
      else if (clr) m_acc = '0;
    end else if (clr) begin
      m_acc = '0;
    end
    if (acc_ok) exp_valid = 1'b1;
    else if (ordy) exp_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1; in_valid = 1'b0; acc_clr = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    m_acc = '0;
    m_cnt = 0;
    exp_valid = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out", {27'd0, out}, 32'd0);
    chk("rst_txn_cnt", {30'd0, txn_cnt}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef LOGIC_ZERO_FLAG_EN
    chk("rst_zero", {31'd0, zero}, 32'd1);
`endif
  endtask

  // Monitor: compares each delivered result with the oldest prediction and tracks the delivery count
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("txn_cnt", {30'd0, txn_cnt}, m_cnt & ((1 << CNT_W) - 1));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_result", 32'd1, 32'd0);
          end else begin
            logic [WIDTH-1:0] e;
            e = exp_q.pop_front();
            chk("out", {27'd0, out}, {27'd0, e});
`ifdef LOGIC_ZERO_FLAG_EN
            chk("zero", {31'd0, zero}, {31'd0, e == '0});
`endif
          end
          m_cnt++;
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    do_reset();
    // OR with immediate delivery
    do_txn(1, 5'b11111, 5'b00111, 2'b01, 0, 0, 1);
    do_txn(0, 5'b00000, 5'b00000, 2'b00, 0, 0, 1);
    // Stall: result held, input blocked, then released
    do_txn(1, 5'b10101, 5'b01010, 2'b10, 0, 0, 0);
    do_txn(1, 5'b00011, 5'b11000, 2'b00, 0, 0, 0);
    do_txn(1, 5'b01100, 5'b00110, 2'b01, 0, 0, 0);
    do_txn(1, 5'b01100, 5'b00110, 2'b01, 0, 0, 1);
    do_txn(0, 5'b00000, 5'b00000, 2'b00, 0, 0, 1);
    // Accumulate ORs after clear
    do_txn(0, 5'b00000, 5'b00000, 2'b00, 0, 1, 1);
    do_txn(1, 5'b00001, 5'b11111, 2'b01, 1, 0, 1);
    do_txn(1, 5'b00100, 5'b11111, 2'b01, 1, 0, 1);
    do_txn(1, 5'b10000, 5'b11111, 2'b01, 1, 0, 1);
    // Clear coinciding with accumulate XOR, then read acc back through OR with zero
    do_txn(1, 5'b11000, 5'b00111, 2'b10, 1, 1, 1);
    do_txn(1, 5'b00000, 5'b11111, 2'b01, 1, 0, 1);
    // Zero results: AND and NOR
    do_txn(1, 5'b10000, 5'b01111, 2'b00, 0, 0, 1);
    do_txn(1, 5'b10000, 5'b01111, 2'b11, 0, 0, 1);
    // Back-to-back deliveries across counter wrap, then reset with a pending result
    for (int i = 0; i < 5; i++) do_txn(1, WIDTH'(i), 5'b10101, 2'b10, 0, 0, 1);
    do_txn(1, 5'b00110, 5'b00011, 2'b00, 0, 0, 0);
    do_reset();
    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset();
      end else begin
        do_txn(($urandom_range(0, 3) != 0), WIDTH'($urandom), WIDTH'($urandom), 2'($urandom),
               ($urandom_range(0, 1) == 1), ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0));
      end
    end
    // Drain
    for (int i = 0; i < 3; i++) do_txn(0, 5'b00000, 5'b00000, 2'b00, 0, 0, 1);
    @(posedge clk);
    #2;
    chk("drain_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
